// File: rtl/gpio_in_debounce_if.sv
// gpio_in_debounce_if: bundles the raw switch inputs and the conditioned
// outputs of gpio_in_debounce. The board/bench side uses the master modport.
// The conditioning block uses the slave modport.
interface gpio_in_debounce_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] raw_i;     // asynchronous raw switch levels
    logic [WIDTH-1:0] db_o;      // debounced level
    logic [WIDTH-1:0] rise_o;    // one-cycle pulse on debounced 0->1
    logic [WIDTH-1:0] fall_o;    // one-cycle pulse on debounced 1->0
    logic             change_o;  // one-cycle pulse, OR of rise_o|fall_o
    logic             tick_o;    // one-cycle sample-tick strobe

    modport master (
        output raw_i,
        input  db_o,
        input  rise_o,
        input  fall_o,
        input  change_o,
        input  tick_o
    );

    modport slave (
        input  raw_i,
        output db_o,
        output rise_o,
        output fall_o,
        output change_o,
        output tick_o
    );
endinterface

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: conditions raw board switches for the SoC gpio_in bus.
// Every bit passes through a two-flop synchronizer. A prescaler shared by
// all channels produces a sample tick every TICK_DIV clocks. On each tick, a
// channel whose synchronized level differs from its debounced level advances
// a stability counter. The new level is accepted after STABLE_TICKS
// consecutive disagreeing ticks. The block also emits registered per-bit
// rise/fall pulses and a combined change strobe.
module gpio_in_debounce #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    gpio_in_debounce_if.slave   bus
);

    // A divider of 1 still needs a one-bit counter; it simply never leaves 0.
    localparam int PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_TICKS - 1);

    // Synchronizer chain
    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;

    // Shared prescaler
    logic [PCNT_W-1:0]           pcnt_q;
    logic [PCNT_W-1:0]           pcnt_d;
    logic                        tick;
    logic                        tick_q;

    // Per-channel qualification state
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            db_q;
    logic [WIDTH-1:0]            db_d;

    // Registered events
    logic [WIDTH-1:0]            rise_q;
    logic [WIDTH-1:0]            rise_d;
    logic [WIDTH-1:0]            fall_q;
    logic [WIDTH-1:0]            fall_d;
    logic                        change_q;
    logic                        change_d;

    // Two-flop synchronizer; the raw pins are asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Prescaler next state: tick on the terminal count, then wrap to 0.
    always_comb begin
        tick   = (pcnt_q == PCNT_LAST);
        pcnt_d = tick ? '0 : (pcnt_q + PCNT_W'(1));
    end

    // Prescaler register; tick_q mirrors the tick that updates db this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick;
        end
    end

    // Per-channel qualification. Any agreeing sample restarts the count.
    // The counter stops at STABLE_TICKS-1 and never wraps.
    always_comb begin
        db_d     = db_q;
        cnt_d    = cnt_q;
        rise_d   = '0;
        fall_d   = '0;
        change_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (tick) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]   = sync2_q[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        change_d = |(rise_d | fall_d);
    end

    // Debounced level, counters and event pulses, updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            db_q     <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    assign bus.db_o     = db_q;
    assign bus.rise_o   = rise_q;
    assign bus.fall_o   = fall_q;
    assign bus.change_o = change_q;
    assign bus.tick_o   = tick_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb_gpio_in_debounce: scenario bench for gpio_in_debounce with TICK_DIV=4,
// STABLE_TICKS=3. Expected debounced events are queued as stimulus is
// applied. A monitor queues every observed event, and each scenario pops
// and compares them.
module tb_gpio_in_debounce;

    typedef struct {
        logic [15:0] rise;
        logic [15:0] fall;
        logic [15:0] db;
        logic        change;
        int          cmin;
        int          cmax;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;

    ev_t  exp_q[$];
    ev_t  obs_q[$];
    ev_t  e;
    ev_t  o;
    ev_t  mon_ev;

    gpio_in_debounce_if #(.WIDTH(16)) bus ();

    gpio_in_debounce #(
        .WIDTH(16),
        .TICK_DIV(4),
        .STABLE_TICKS(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every cycle that carries an event
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (bus.change_o !== 1'b0 || bus.rise_o !== 16'h0 || bus.fall_o !== 16'h0)) begin
            mon_ev.rise   = bus.rise_o;
            mon_ev.fall   = bus.fall_o;
            mon_ev.db     = bus.db_o;
            mon_ev.change = bus.change_o;
            mon_ev.cmin   = cyc;
            mon_ev.cmax   = cyc;
            obs_q.push_back(mon_ev);
        end
    end

    task automatic push_exp(input logic [15:0] rise, input logic [15:0] fall,
                            input logic [15:0] db, input int cmin, input int cmax);
        ev_t x;
        x.rise = rise; x.fall = fall; x.db = db; x.change = 1'b1;
        x.cmin = cmin; x.cmax = cmax;
        exp_q.push_back(x);
    endtask

    // Bounded wait for the monitor to capture an event
    task automatic wait_obs(input int budget);
        for (int w = 0; w < budget; w++) begin
            if (obs_q.size() > 0) return;
            @(negedge clk);
        end
    endtask

    task automatic drive_after_edge(input logic [15:0] v);
        @(posedge clk);
        #1;
        bus.raw_i = v;
    endtask

    task automatic test_reset;
        int r;
        rst_n = 1'b0;
        bus.raw_i = 16'hFFFF;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.db_o !== 16'h0) begin n_errors++; $display("FAIL reset_db: got %h, want 0000", bus.db_o); end
        n_checks++; if (bus.rise_o !== 16'h0) begin n_errors++; $display("FAIL reset_rise: got %h, want 0000", bus.rise_o); end
        n_checks++; if (bus.fall_o !== 16'h0) begin n_errors++; $display("FAIL reset_fall: got %h, want 0000", bus.fall_o); end
        n_checks++; if (bus.change_o !== 1'b0) begin n_errors++; $display("FAIL reset_change: got %b, want 0", bus.change_o); end
        n_checks++; if (bus.tick_o !== 1'b0) begin n_errors++; $display("FAIL reset_tick: got %b, want 0", bus.tick_o); end
        rst_n = 1'b1;
        r = cyc;
        push_exp(16'hFFFF, 16'h0, 16'hFFFF, r + 12, r + 12);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.tick_o !== ((k % 4) == 0)) begin
                n_errors++; $display("FAIL reset_tick_seq: edge %0d tick_o=%b, want %b", k, bus.tick_o, (k % 4) == 0);
            end
        end
        wait_obs(10);
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_checks++; n_errors++; $display("FAIL reset_requal: no event, want rise=ffff");
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.rise !== e.rise || o.fall !== e.fall || o.db !== e.db || o.change !== 1'b1) begin
                n_errors++; $display("FAIL reset_requal: rise=%h fall=%h db=%h chg=%b, want rise=%h fall=%h db=%h chg=1", o.rise, o.fall, o.db, o.change, e.rise, e.fall, e.db);
            end
            n_checks++;
            if (o.cmin < e.cmin || o.cmin > e.cmax) begin
                n_errors++; $display("FAIL reset_requal_lat: cycle %0d, want %0d..%0d", o.cmin, e.cmin, e.cmax);
            end
        end
        repeat (12) @(negedge clk);
        n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL reset_extra: %0d extra events, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_clean_step;
        int c0;
        for (int s = 0; s < 2; s++) begin
            drive_after_edge(s == 0 ? 16'h0000 : 16'h0001);
            c0 = cyc;
            if (s == 0) push_exp(16'h0, 16'hFFFF, 16'h0000, c0 + 11, c0 + 14);
            else        push_exp(16'h0001, 16'h0, 16'h0001, c0 + 11, c0 + 14);
            wait_obs(25);
            if (obs_q.size() == 0 || exp_q.size() == 0) begin
                n_checks++; n_errors++; $display("FAIL step_%0d: no event seen", s);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                n_checks++;
                if (o.rise !== e.rise || o.fall !== e.fall || o.db !== e.db || o.change !== 1'b1) begin
                    n_errors++; $display("FAIL step_%0d: rise=%h fall=%h db=%h chg=%b, want rise=%h fall=%h db=%h chg=1", s, o.rise, o.fall, o.db, o.change, e.rise, e.fall, e.db);
                end
                n_checks++;
                if (o.cmin < e.cmin || o.cmin > e.cmax) begin
                    n_errors++; $display("FAIL step_%0d_lat: cycle %0d, want %0d..%0d", s, o.cmin, e.cmin, e.cmax);
                end
            end
            repeat (12) @(negedge clk);
            n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL step_%0d_extra: %0d extra events, want 0", s, obs_q.size()); obs_q.delete(); end
        end
    endtask

    task automatic test_glitch;
        logic [15:0] seen;
        seen = 16'h0;
        drive_after_edge(16'h0021);
        repeat (8) @(posedge clk);
        #1;
        bus.raw_i = 16'h0001;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            seen = seen | bus.db_o;
        end
        n_checks++; if (seen[5] !== 1'b0) begin n_errors++; $display("FAIL glitch_db5: db_o[5] seen %b, want 0", seen[5]); end
        n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL glitch_events: %0d events, want 0", obs_q.size()); obs_q.delete(); end
        n_checks++; if (bus.db_o !== 16'h0001) begin n_errors++; $display("FAIL glitch_db: got %h, want 0001", bus.db_o); end
    endtask

    task automatic test_bounce;
        int c0;
        logic [15:0] v;
        v = 16'h0001;
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            v[2] = ~v[2];
            bus.raw_i = v;
            repeat (3) @(posedge clk);
            #1;
        end
        bus.raw_i = 16'h0005;
        c0 = cyc;
        push_exp(16'h0004, 16'h0, 16'h0005, c0 + 3, c0 + 14);
        wait_obs(25);
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_checks++; n_errors++; $display("FAIL bounce: no event, want rise=0004");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o.rise !== e.rise || o.fall !== e.fall || o.db !== e.db || o.change !== 1'b1) begin
                n_errors++; $display("FAIL bounce: rise=%h fall=%h db=%h chg=%b, want rise=%h fall=%h db=%h chg=1", o.rise, o.fall, o.db, o.change, e.rise, e.fall, e.db);
            end
            n_checks++;
            if (o.cmin < e.cmin || o.cmin > e.cmax) begin
                n_errors++; $display("FAIL bounce_lat: cycle %0d, want %0d..%0d", o.cmin, e.cmin, e.cmax);
            end
        end
        repeat (12) @(negedge clk);
        n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL bounce_extra: %0d extra events, want 0", obs_q.size()); obs_q.delete(); end
        n_checks++; if (bus.db_o !== 16'h0005) begin n_errors++; $display("FAIL bounce_db: got %h, want 0005", bus.db_o); end
    endtask

    task automatic test_simultaneous;
        int c0;
        logic [15:0] prev;
        logic [15:0] nxt;
        prev = 16'h0005;
        for (int s = 0; s < 2; s++) begin
            nxt = (s == 0) ? 16'h0080 : 16'h0008;
            drive_after_edge(nxt);
            c0 = cyc;
            push_exp(nxt & ~prev, prev & ~nxt, nxt, c0 + 11, c0 + 14);
            wait_obs(25);
            if (obs_q.size() == 0 || exp_q.size() == 0) begin
                n_checks++; n_errors++; $display("FAIL simul_%0d: no event seen", s);
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                n_checks++;
                if (o.rise !== e.rise || o.fall !== e.fall || o.db !== e.db || o.change !== 1'b1) begin
                    n_errors++; $display("FAIL simul_%0d: rise=%h fall=%h db=%h chg=%b, want rise=%h fall=%h db=%h chg=1", s, o.rise, o.fall, o.db, o.change, e.rise, e.fall, e.db);
                end
                n_checks++;
                if (o.cmin < e.cmin || o.cmin > e.cmax) begin
                    n_errors++; $display("FAIL simul_%0d_lat: cycle %0d, want %0d..%0d", s, o.cmin, e.cmin, e.cmax);
                end
            end
            repeat (12) @(negedge clk);
            n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL simul_%0d_extra: %0d extra events, want 0", s, obs_q.size()); obs_q.delete(); end
            prev = nxt;
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        int ticks;
        int r;
        ticks = 0;
        drive_after_edge(16'h0208);
        c0 = cyc;
        for (int k = 0; k < 40 && ticks < 2; k++) begin
            @(negedge clk);
            if (bus.tick_o === 1'b1 && cyc >= c0 + 3) ticks++;
        end
        n_checks++; if (ticks != 2) begin n_errors++; $display("FAIL midrst_ticks: saw %0d ticks, want 2", ticks); end
        n_checks++; if (bus.db_o !== 16'h0008) begin n_errors++; $display("FAIL midrst_pre_db: got %h, want 0008", bus.db_o); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.db_o !== 16'h0000) begin n_errors++; $display("FAIL midrst_async_db: got %h, want 0000", bus.db_o); end
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        push_exp(16'h0208, 16'h0, 16'h0208, r + 12, r + 12);
        wait_obs(30);
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_checks++; n_errors++; $display("FAIL midrst_requal: no event, want rise=0208");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o.rise !== e.rise || o.fall !== e.fall || o.db !== e.db || o.change !== 1'b1) begin
                n_errors++; $display("FAIL midrst_requal: rise=%h fall=%h db=%h chg=%b, want rise=%h fall=%h db=%h chg=1", o.rise, o.fall, o.db, o.change, e.rise, e.fall, e.db);
            end
            n_checks++;
            if (o.cmin < e.cmin || o.cmin > e.cmax) begin
                n_errors++; $display("FAIL midrst_lat: cycle %0d, want %0d..%0d", o.cmin, e.cmin, e.cmax);
            end
        end
        repeat (12) @(negedge clk);
        n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL midrst_extra: %0d extra events, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        cyc = 0;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.raw_i = 16'hFFFF;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
